dmem_resp_unit: RTL and testbench

Data-side memory responder for the pipeline. It accepts one load/store request from the M1 stage and runs it on an SRAM-like handshake bus to data memory (addr_ok, then data_ok). It drives data_rdata and dcache_busy to the MEM stage, so a load stalls the MEM stage until its read data is captured.

---
 rtl/dmem_resp_unit.sv | 137 +++++++++++++
 tb/tb_dmem_resp_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp_unit.sv
// Data-memory responder: one load/store at a time over an addr_ok/data_ok SRAM-style bus.
// Optional store posting is enabled by defining DMEM_STORE_POST_EN.
module dmem_resp_unit #(
    parameter int MAX_WR_OUT = 4,
    parameter int CNT_W      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] data_rdata,
    output logic        dcache_busy,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    if ((1 << CNT_W) <= MAX_WR_OUT) begin : g_bad_cfg
        $error("dmem_resp_unit: CNT_W too narrow for MAX_WR_OUT");
    end

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        w_accept;
    logic        w_idle_rdy;
    logic        w_post_store;

`ifdef DMEM_STORE_POST_EN
    logic [CNT_W-1:0] r_wr_cnt;
    logic             w_inc;
    logic             w_dec;

    assign w_inc        = (r_state == S_ADDR) && mem_addr_ok && r_wr;
    // Acks with nothing outstanding are strays and must not wrap the counter.
    assign w_dec        = mem_data_ok && (r_state != S_DATA) && ((r_wr_cnt != '0) || w_inc);
    assign w_idle_rdy   = req_wr ? (r_wr_cnt < CNT_W'(MAX_WR_OUT)) : (r_wr_cnt == '0);
    assign w_post_store = r_wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_cnt <= '0;
        end else if (w_inc && !w_dec) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
        end else if (w_dec && !w_inc) begin
            r_wr_cnt <= r_wr_cnt - 1'b1;
        end
    end
`else
    assign w_idle_rdy   = 1'b1;
    assign w_post_store = 1'b0;
`endif

    assign req_ready   = (r_state == S_IDLE) && w_idle_rdy;
    assign w_accept    = req_valid && req_ready;
    assign dcache_busy = (r_state == S_ADDR) || (r_state == S_DATA);
    assign data_rdata  = r_rdata;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_ADDR;
            S_ADDR: if (mem_addr_ok) w_state_nxt = w_post_store ? S_IDLE : S_DATA;
            S_DATA: if (mem_data_ok) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_wr    <= req_wr;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if ((r_state == S_DATA) && mem_data_ok && !r_wr) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Bus fields come straight from the latch so they stay stable until addr_ok.
    assign mem_req  = (r_state == S_ADDR);
    assign mem_wr   = r_wr;
    assign mem_addr = r_addr;
    assign mem_size = (r_size == 2'd3) ? 2'd2 : r_size;

    always_comb begin
        mem_wstrb = 4'b0000;
        mem_wdata = r_wdata;
        case (r_size)
            2'd0: begin
                mem_wstrb = 4'b0001 << r_addr[1:0];
                mem_wdata = {4{r_wdata[7:0]}};
            end
            2'd1: begin
                mem_wstrb = 4'b0011 << {r_addr[1], 1'b0};
                mem_wdata = {2{r_wdata[15:0]}};
            end
            default: begin
                mem_wstrb = 4'b1111;
                mem_wdata = r_wdata;
            end
        endcase
        if (!r_wr) begin
            mem_wstrb = 4'b0000;
        end
    end

endmodule

// File: tb/tb_dmem_resp_unit.sv
// Directed + randomized bench for dmem_resp_unit; the bench itself plays the memory bus.
module tb_dmem_resp_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, data_rdata;
    logic        dcache_busy, mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] ref_mem [16];
    logic [31:0] last_load;
    logic [3:0]  got_strb;
    logic [31:0] got_wdata;

    always #5 clk = ~clk;

    dmem_resp_unit dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .data_rdata(data_rdata), .dcache_busy(dcache_busy),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference rules stated in terms of byte offsets and lane counts.
    function automatic logic [3:0] model_strb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (!wr) return 4'd0;
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off < 2) ? 4'b0011 : 4'b1100;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [3:0]  s;
        logic [31:0] w;
        s = model_strb(1'b1, sz, a);
        w = model_wdata(sz, d);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a[5:2]][8*b +: 8] = w[8*b +: 8];
    endtask

    // Entered and left at a negedge; bus latencies adly/ddly in cycles.
    task automatic do_txn(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                          input logic [31:0] wd, input int adly, input int ddly);
        int busy_n;
        busy_n    = 0;
        req_valid = 1'b1; req_wr = wr; req_size = sz; req_addr = addr; req_wdata = wd;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wr = $urandom; req_size = 2'($urandom);
        for (int i = 0; i <= adly; i++) begin
            chk("addr_mem_req", 32'(mem_req), 32'd1);
            chk("addr_mem_addr", mem_addr, addr);
            chk("addr_req_ready", 32'(req_ready), 32'd0);
            if (dcache_busy) busy_n++;
            if (i == adly) begin
                mem_addr_ok = 1'b1;
                got_strb  = mem_wstrb;
                got_wdata = mem_wdata;
                chk("mem_wr", 32'(mem_wr), 32'(wr));
                chk("mem_size", 32'(mem_size), (sz == 2'd3) ? 32'd2 : 32'(sz));
                chk("mem_wstrb", 32'(mem_wstrb), 32'(model_strb(wr, sz, addr)));
                if (wr) chk("mem_wdata", mem_wdata, model_wdata(sz, wd));
            end
            @(negedge clk);
        end
        mem_addr_ok = 1'b0;
`ifdef DMEM_STORE_POST_EN
        if (wr) begin
            chk("post_busy_cycles", 32'(busy_n), 32'(adly + 1));
            chk("post_busy_clear", 32'(dcache_busy), 32'd0);
            model_store(sz, addr, wd);
            mem_data_ok = 1'b1;
            @(negedge clk);
            mem_data_ok = 1'b0;
            chk("post_rdata_hold", data_rdata, last_load);
            return;
        end
`endif
        for (int i = 0; i <= ddly; i++) begin
            chk("data_mem_req", 32'(mem_req), 32'd0);
            chk("data_req_ready", 32'(req_ready), 32'd0);
            if (dcache_busy) busy_n++;
            mem_rdata = $urandom;
            if (i == ddly) begin
                mem_data_ok = 1'b1;
                if (!wr) mem_rdata = ref_mem[addr[5:2]];
            end
            @(negedge clk);
        end
        mem_data_ok = 1'b0;
        mem_rdata   = $urandom;
        if (wr) model_store(sz, addr, wd);
        else last_load = ref_mem[addr[5:2]];
        chk("busy_cycles", 32'(busy_n), 32'(adly + ddly + 2));
        chk("busy_clear", 32'(dcache_busy), 32'd0);
        chk("data_rdata", data_rdata, last_load);
    endtask

    initial begin
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] a;
        reset = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
        last_load = 32'd0;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[0] = 32'hDEAD_BEEF;

        @(negedge clk);
        chk("rst_busy", 32'(dcache_busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rdata", data_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        do_txn(1'b0, 2'd2, 32'h1000, 32'd0, 0, 0);
        chk("lw_deadbeef", data_rdata, 32'hDEAD_BEEF);
        chk("lw_wstrb", 32'(got_strb), 32'd0);
        do_txn(1'b0, 2'd2, 32'h1004, 32'd0, 3, 2);

        do_txn(1'b1, 2'd0, 32'h1003, 32'h0000_00A5, 0, 0);
        chk("sb_wstrb", 32'(got_strb), 32'h8);
        chk("sb_wdata", got_wdata, 32'hA5A5_A5A5);
        do_txn(1'b1, 2'd1, 32'h1002, 32'h0000_1234, 1, 0);
        chk("sh_wstrb", 32'(got_strb), 32'hC);
        chk("sh_wdata", got_wdata, 32'h1234_1234);
        do_txn(1'b1, 2'd2, 32'h2000, 32'h0BAD_F00D, 1, 2);
        chk("sw_rdata_kept", data_rdata, last_load);

        // Reset while a load waits in DATA; a stray ack afterwards must be ignored.
        req_valid = 1'b1; req_wr = 1'b0; req_size = 2'd2; req_addr = 32'h1008;
        @(negedge clk);
        req_valid = 1'b0; mem_addr_ok = 1'b1;
        @(negedge clk);
        mem_addr_ok = 1'b0;
        chk("pre_rst_busy", 32'(dcache_busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", 32'(dcache_busy), 32'd0);
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_mem_req", 32'(mem_req), 32'd0);
        chk("midrst_rdata", data_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0; last_load = 32'd0;
        mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_data_ok = 1'b0;
        chk("stray_ack_rdata", data_rdata, 32'd0);
        chk("stray_ack_busy", 32'(dcache_busy), 32'd0);

`ifdef DMEM_STORE_POST_EN
        for (int k = 0; k < 4; k++) begin
            req_valid = 1'b1; req_wr = 1'b1; req_size = 2'd2;
            req_addr = 32'h1010 + 32'(4 * k); req_wdata = $urandom;
            chk("post_accept", 32'(req_ready), 32'd1);
            model_store(2'd2, req_addr, req_wdata);
            @(negedge clk);
            req_valid = 1'b0; mem_addr_ok = 1'b1;
            @(negedge clk);
            mem_addr_ok = 1'b0;
            chk("post_idle", 32'(dcache_busy), 32'd0);
        end
        req_wr = 1'b1;
        chk("post_5th_stall", 32'(req_ready), 32'd0);
        req_wr = 1'b0;
        chk("post_load_stall", 32'(req_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            req_wr = 1'b0;
            chk("post_drain_load_wait", 32'(req_ready), 32'd0);
            mem_data_ok = 1'b1;
            @(negedge clk);
        end
        mem_data_ok = 1'b0;
        chk("post_load_ready", 32'(req_ready), 32'd1);
`endif

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom);
            sz = 2'($urandom);
            a  = 32'h1000 + 32'($urandom_range(0, 15) * 4);
            if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
            if (sz == 2'd1) a = a + 32'($urandom_range(0, 1) * 2);
            do_txn(wr, sz, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
